// File: rtl/cpu_pkg.sv
// Shared encodings for the RISC controller: opcode/op fields, FSM states, register-select and writeback codes.
// CTRL_SINGLE_STEP_EN adds the S_STEP hold state in front of every instruction fetch.
package cpu_pkg;

  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_MEM  = 2'b00;

  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b10;
  localparam logic [1:0] VSEL_PC    = 2'b11;

  typedef enum logic [4:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPDPC,
    S_DEC,
    S_WRI,
    S_GETA,
    S_GETB,
    S_SHC,
    S_ALU,
    S_CMP,
    S_WRC,
    S_ADR,
    S_MRD,
    S_WRM,
    S_GETBD,
    S_MWR,
`ifdef CTRL_SINGLE_STEP_EN
    S_STEP,
`endif
    S_HALT
  } state_t;

  typedef struct packed {
    logic       loadir;
    logic       loadpc;
    logic       resetpc;
    logic       msel;
    logic       mem_write;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/cpu_controller.sv
// Moore controller for the simple RISC datapath: fetch, PC update, decode, then a per-instruction execute sequence.
// Optional single-step hold before each fetch when CTRL_SINGLE_STEP_EN is defined (adds the step input).
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       loadir,
  output logic       loadpc,
  output logic       resetpc,
  output logic       msel,
  output logic       mem_write,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic       halted
);

`ifdef CTRL_SINGLE_STEP_EN
  localparam state_t FETCH_ENTRY = S_STEP;
`else
  localparam state_t FETCH_ENTRY = S_IF1;
`endif

  state_t state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  // Outputs depend only on state_q; opcode/op steer next-state only.
  always_comb begin
    state_d   = state_q;
    ctrl      = '0;
    ctrl.nsel = NSEL_RN;
    ctrl.vsel = VSEL_C;
    case (state_q)
      S_RST: begin
        ctrl.loadpc  = 1'b1;
        ctrl.resetpc = 1'b1;
        state_d      = FETCH_ENTRY;
      end
`ifdef CTRL_SINGLE_STEP_EN
      S_STEP: if (step) state_d = S_IF1;
`endif
      S_IF1: state_d = S_IF2;
      S_IF2: begin
        ctrl.loadir = 1'b1;
        state_d     = S_UPDPC;
      end
      S_UPDPC: begin
        ctrl.loadpc = 1'b1;
        state_d     = S_DEC;
      end
      S_DEC: begin
        if (opcode == OPC_MOV && op == OP_MOVI)      state_d = S_WRI;
        else if (opcode == OPC_MOV && op == OP_MOVR) state_d = S_GETB;
        else if (opcode == OPC_ALU)                  state_d = S_GETA;
        else if (opcode == OPC_LDR && op == OP_MEM)  state_d = S_GETA;
        else if (opcode == OPC_STR && op == OP_MEM)  state_d = S_GETA;
        else                                         state_d = S_HALT;
      end
      S_WRI: begin
        ctrl.vsel  = VSEL_IMM;
        ctrl.write = 1'b1;
        state_d    = FETCH_ENTRY;
      end
      S_GETA: begin
        ctrl.loada = 1'b1;
        state_d    = (opcode == OPC_ALU) ? S_GETB : S_ADR;
      end
      S_GETB: begin
        ctrl.nsel  = NSEL_RM;
        ctrl.loadb = 1'b1;
        if (opcode == OPC_MOV)  state_d = S_SHC;
        else if (op == OP_CMP)  state_d = S_CMP;
        else                    state_d = S_ALU;
      end
      S_SHC: begin
        ctrl.asel  = 1'b1;
        ctrl.loadc = 1'b1;
        state_d    = S_WRC;
      end
      S_ALU: begin
        ctrl.loadc = 1'b1;
        state_d    = S_WRC;
      end
      // Compare updates status only; nothing is written back.
      S_CMP: begin
        ctrl.loads = 1'b1;
        state_d    = FETCH_ENTRY;
      end
      S_WRC: begin
        ctrl.nsel  = NSEL_RD;
        ctrl.write = 1'b1;
        state_d    = FETCH_ENTRY;
      end
      S_ADR: begin
        ctrl.bsel  = 1'b1;
        ctrl.loadc = 1'b1;
        state_d    = (opcode == OPC_STR) ? S_GETBD : S_MRD;
      end
      S_MRD: begin
        ctrl.msel = 1'b1;
        state_d   = S_WRM;
      end
      S_WRM: begin
        ctrl.msel  = 1'b1;
        ctrl.nsel  = NSEL_RD;
        ctrl.vsel  = VSEL_MDATA;
        ctrl.write = 1'b1;
        state_d    = FETCH_ENTRY;
      end
      S_GETBD: begin
        ctrl.nsel  = NSEL_RD;
        ctrl.loadb = 1'b1;
        state_d    = S_MWR;
      end
      S_MWR: begin
        ctrl.msel      = 1'b1;
        ctrl.mem_write = 1'b1;
        state_d        = FETCH_ENTRY;
      end
      S_HALT: ctrl.halted = 1'b1;
      default: state_d = S_HALT;
    endcase
  end

  assign loadir    = ctrl.loadir;
  assign loadpc    = ctrl.loadpc;
  assign resetpc   = ctrl.resetpc;
  assign msel      = ctrl.msel;
  assign mem_write = ctrl.mem_write;
  assign nsel      = ctrl.nsel;
  assign vsel      = ctrl.vsel;
  assign write     = ctrl.write;
  assign loada     = ctrl.loada;
  assign loadb     = ctrl.loadb;
  assign asel      = ctrl.asel;
  assign bsel      = ctrl.bsel;
  assign loadc     = ctrl.loadc;
  assign loads     = ctrl.loads;
  assign halted    = ctrl.halted;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed, table-driven bench for cpu_controller; expected strobes per state are hand-derived constants.
// Build with CTRL_SINGLE_STEP_EN to also exercise the single-step hold.
module tb_cpu_controller;

  // Packed order: {loadir,loadpc,resetpc,msel,mem_write}_{nsel}_{vsel}_{write,loada,loadb,asel,bsel,loadc,loads,halted}
  localparam logic [17:0] E_RST   = 18'b01100_001_00_00000000;
  localparam logic [17:0] E_IF1   = 18'b00000_001_00_00000000;
  localparam logic [17:0] E_IF2   = 18'b10000_001_00_00000000;
  localparam logic [17:0] E_UPD   = 18'b01000_001_00_00000000;
  localparam logic [17:0] E_DEC   = 18'b00000_001_00_00000000;
  localparam logic [17:0] E_WRI   = 18'b00000_001_01_10000000;
  localparam logic [17:0] E_GETA  = 18'b00000_001_00_01000000;
  localparam logic [17:0] E_GETB  = 18'b00000_100_00_00100000;
  localparam logic [17:0] E_SHC   = 18'b00000_001_00_00010100;
  localparam logic [17:0] E_ALU   = 18'b00000_001_00_00000100;
  localparam logic [17:0] E_CMP   = 18'b00000_001_00_00000010;
  localparam logic [17:0] E_WRC   = 18'b00000_010_00_10000000;
  localparam logic [17:0] E_ADR   = 18'b00000_001_00_00001100;
  localparam logic [17:0] E_MRD   = 18'b00010_001_00_00000000;
  localparam logic [17:0] E_WRM   = 18'b00010_010_10_10000000;
  localparam logic [17:0] E_GETBD = 18'b00000_010_00_00100000;
  localparam logic [17:0] E_MWR   = 18'b00011_001_00_00000000;
  localparam logic [17:0] E_HALT  = 18'b00000_001_00_00000001;

  logic       clk, reset;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       step;
  logic       loadir, loadpc, resetpc, msel, mem_write, write;
  logic       loada, loadb, asel, bsel, loadc, loads, halted;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic [17:0] got;

  assign got = {loadir, loadpc, resetpc, msel, mem_write, nsel, vsel,
                write, loada, loadb, asel, bsel, loadc, loads, halted};

  cpu_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .loadir(loadir), .loadpc(loadpc), .resetpc(resetpc), .msel(msel),
    .mem_write(mem_write), .nsel(nsel), .vsel(vsel), .write(write),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
    .loadc(loadc), .loads(loads), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  opc;
    logic [1:0]  op;
    logic [17:0] exp;
    bit          fe;
    string       name;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic [2:0] c, input logic [1:0] p,
                     input logic [17:0] e, input bit fe, input string nm);
    vec_t v;
    v.rst = r; v.opc = c; v.op = p; v.exp = e; v.fe = fe; v.name = nm;
    vq.push_back(v);
  endtask

  task automatic add_fetch(input logic [2:0] c, input logic [1:0] p);
    add(1'b0, c, p, E_IF1, 1'b1, "IF1");
    add(1'b0, c, p, E_IF2, 1'b0, "IF2");
    add(1'b0, c, p, E_UPD, 1'b0, "UPDPC");
    add(1'b0, c, p, E_DEC, 1'b0, "DEC");
  endtask

  task automatic check(input string nm, input logic [17:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, got, exp);
    end else begin
      $display("vec %0d %s: %b ok", n_vec, nm, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until the outputs show the wanted pattern, bounded; the final check flags a timeout.
  task automatic run_until(input logic [17:0] want, input string nm);
    for (int k = 0; k < 30; k++) begin
      if (got === want) break;
      tick();
    end
    check(nm, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = 3'b000; op = 2'b00; step = 1'b1;

    add(1'b1, 3'b000, 2'b00, E_RST, 1'b0, "reset");
    add_fetch(3'b110, 2'b10);
    add(1'b0, 3'b110, 2'b10, E_WRI, 1'b0, "MOVI WRI");
    add_fetch(3'b110, 2'b00);
    add(1'b0, 3'b110, 2'b00, E_GETB, 1'b0, "MOVR GETB");
    add(1'b0, 3'b110, 2'b00, E_SHC,  1'b0, "MOVR SHC");
    add(1'b0, 3'b110, 2'b00, E_WRC,  1'b0, "MOVR WRC");
    add_fetch(3'b101, 2'b00);
    add(1'b0, 3'b101, 2'b00, E_GETA, 1'b0, "ADD GETA");
    add(1'b0, 3'b101, 2'b00, E_GETB, 1'b0, "ADD GETB");
    add(1'b0, 3'b101, 2'b00, E_ALU,  1'b0, "ADD ALU");
    add(1'b0, 3'b101, 2'b00, E_WRC,  1'b0, "ADD WRC");
    add_fetch(3'b101, 2'b01);
    add(1'b0, 3'b101, 2'b01, E_GETA, 1'b0, "CMP GETA");
    add(1'b0, 3'b101, 2'b01, E_GETB, 1'b0, "CMP GETB");
    add(1'b0, 3'b101, 2'b01, E_CMP,  1'b0, "CMP ALU");
    add_fetch(3'b011, 2'b00);
    add(1'b0, 3'b011, 2'b00, E_GETA, 1'b0, "LDR GETA");
    add(1'b0, 3'b011, 2'b00, E_ADR,  1'b0, "LDR ADR");
    add(1'b0, 3'b011, 2'b00, E_MRD,  1'b0, "LDR MRD");
    add(1'b0, 3'b011, 2'b00, E_WRM,  1'b0, "LDR WRM");
    add_fetch(3'b100, 2'b00);
    add(1'b0, 3'b100, 2'b00, E_GETA,  1'b0, "STR GETA");
    add(1'b0, 3'b100, 2'b00, E_ADR,   1'b0, "STR ADR");
    add(1'b0, 3'b100, 2'b00, E_GETBD, 1'b0, "STR GETBD");
    add(1'b0, 3'b100, 2'b00, E_MWR,   1'b0, "STR MWR");
    add_fetch(3'b010, 2'b00);
    add(1'b0, 3'b010, 2'b00, E_HALT, 1'b0, "ILL HALT");
    add(1'b0, 3'b110, 2'b10, E_HALT, 1'b0, "ILL HALT hold1");
    add(1'b0, 3'b110, 2'b10, E_HALT, 1'b0, "ILL HALT hold2");
    add(1'b1, 3'b110, 2'b01, E_RST,  1'b0, "reset from HALT");
    add_fetch(3'b110, 2'b01);
    add(1'b0, 3'b110, 2'b01, E_HALT, 1'b0, "MOV op01 HALT");

    foreach (vq[i]) begin
      reset  = vq[i].rst;
      opcode = vq[i].opc;
      op     = vq[i].op;
      tick();
      check(vq[i].name, vq[i].exp);
`ifdef CTRL_SINGLE_STEP_EN
      // First edge landed in S_STEP; step is held high so the next edge enters S_IF1.
      if (vq[i].fe) begin
        tick();
        check({vq[i].name, " after STEP"}, E_IF1);
      end
`endif
    end

    // Asynchronous reset in the middle of S_ALU.
    reset = 1'b1; tick();
    reset = 1'b0; opcode = 3'b101; op = 2'b10;
    run_until(E_ALU, "reach S_ALU");
    #2 reset = 1'b1;
    #1 check("async reset mid-ALU", E_RST);
    tick();
    check("reset held at edge", E_RST);
    reset = 1'b0;

    // HALT opcode holds indefinitely.
    opcode = 3'b111; op = 2'b11;
    run_until(E_HALT, "reach HALT 111");
    for (int k = 0; k < 6; k++) begin
      opcode = 3'(k);
      tick();
      check("HALT held", E_HALT);
    end

`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b0; reset = 1'b1; opcode = 3'b110; op = 2'b10;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("STEP hold", E_IF1);
    end
    step = 1'b1;
    tick();
    check("STEP -> IF1", E_IF1);
    step = 1'b0;
    tick();
    check("IF2 after step", E_IF2);
    tick(); check("UPDPC after step", E_UPD);
    tick(); check("DEC after step", E_DEC);
    tick(); check("WRI after step", E_WRI);
    tick(); check("back in STEP", E_IF1);
    tick(); check("STEP still held", E_IF1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
